// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtracter built around one full-adder cell; SUB port and subtract path exist only with SERIAL_SUB_EN.
module fa (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic SUM,
  output logic CARRY
);
  assign SUM   = A ^ B ^ C;
  assign CARRY = (A & B) | (C & (A ^ B));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
`ifdef SERIAL_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, full;
  logic [WIDTH-2:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, cout_q, cout_d, done_q, done_d, sub, sum, carry;
`ifdef SERIAL_SUB_EN
  assign sub = SUB;
`else
  assign sub = 1'b0;
`endif
  fa u_fa (.A(a_q[0]), .B(b_q[0]), .C(cy_q), .SUM(sum), .CARRY(carry));
  // r_q holds the low bits gathered so far; the current SUM completes the word
  assign full = {sum, r_q};
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: if (START) begin
        a_d     = A_IN;
        b_d     = sub ? ~B_IN : B_IN;
        cy_d    = sub;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = carry;
        r_d   = full[WIDTH-1:1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = full;
          cout_d   = carry;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end
  assign BUSY   = state_q != S_IDLE;
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign COUT   = cout_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of serial_add_sub timing, arithmetic, START masking and CLR abort.
module tb_serial_add_sub;
  localparam int W = 8;
  logic CLK = 1'b0, CLR = 1'b1, START = 1'b0, SUB = 1'b0;
  logic [W-1:0] A_IN = '0, B_IN = '0, RESULT;
  logic BUSY, DONE, COUT;
  int n_chk = 0, n_err = 0;
  serial_add_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .A_IN(A_IN), .B_IN(B_IN),
`ifdef SERIAL_SUB_EN
    .SUB(SUB),
`endif
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] r, input logic c);
    A_IN = a; B_IN = b; SUB = s; START = 1'b1;
    tick();
    START = 1'b0; A_IN = '0; B_IN = '0; SUB = 1'b0;
    check("busy_e0", BUSY, 1);
    check("done_e0", DONE, 0);
    for (int i = 1; i < W; i++) begin
      tick();
      check("busy_shift", BUSY, 1);
      check("done_shift", DONE, 0);
    end
    tick();
    check("done_pulse", DONE, 1);
    check("busy_done", BUSY, 1);
    check("result", RESULT, r);
    check("cout", COUT, c);
    tick();
    check("done_clear", DONE, 0);
    check("busy_idle", BUSY, 0);
    check("result_hold", RESULT, r);
  endtask
  initial begin
    tick(); tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 0);
    check("rst_cout", COUT, 0);
    CLR = 1'b0;
    tick();
    check("idle_busy", BUSY, 0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op(8'hA5, 8'hC3, 1'b0, 8'h68, 1'b1);
`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    run_op(8'h37, 8'h37, 1'b1, 8'h00, 1'b1);
`endif
    // START re-pulsed at edges 3 and 8 must be ignored; edge 10 is accepted
    for (int e = 0; e <= 18; e++) begin
      START = (e == 0 || e == 3 || e == 8 || e == 10);
      A_IN = (e == 0) ? 8'h5A : (e == 10) ? 8'h11 : 8'hFF;
      B_IN = (e == 0) ? 8'h3C : (e == 10) ? 8'h22 : 8'hFF;
      tick();
      check("ign_done", DONE, (e == 8 || e == 18));
      check("ign_busy", BUSY, (e != 9));
      if (e >= 8 && e < 18) check("ign_result", RESULT, 8'h96);
    end
    check("ign_result2", RESULT, 8'h33);
    START = 1'b0;
    tick();
    check("ign_idle", BUSY, 0);
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    // abort with CLR at edge 4
    A_IN = 8'h11; B_IN = 8'h22; START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    check("clr_pre_result", RESULT, 8'h96);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("clr_result", RESULT, 0);
    check("clr_cout", COUT, 0);
    check("clr_busy", BUSY, 0);
    check("clr_done", DONE, 0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("clr_no_done", DONE, 0);
      check("clr_stay_idle", BUSY, 0);
    end
    run_op(8'h80, 8'h81, 1'b0, 8'h01, 1'b1);
    // START held high: a new op every W+2 cycles
    A_IN = 8'h01; B_IN = 8'h01; START = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      tick();
      check("hold_done", DONE, (e % 10 == 8));
      check("hold_busy", BUSY, (e % 10 != 9));
      if (e % 10 == 8) check("hold_result", RESULT, 8'h02);
    end
    START = 1'b0;
    for (int i = 0; i < W + 2; i++) tick();
    check("final_idle", BUSY, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
